// File: rtl/hex_display_scan.sv
// N-digit hex 7-segment driver: tear-free frame-aligned value update, scanned and
// static segment outputs, leading-zero suppression, per-digit blank and blink.
module hex_display_scan #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLINK_FRAMES = 250
) (
  input  logic                    CLOCK_50,
  input  logic                    RESETN,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic                    load,
  input  logic                    lz_en,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [6:0]              HEX_SEG,
  output logic [NUM_DIGITS-1:0]   DIG_EN,
  output logic [7*NUM_DIGITS-1:0] HEX_ALL,
  output logic                    frame_tick
);

  localparam int unsigned VAL_W = 4 * NUM_DIGITS;
  localparam int unsigned ALL_W = 7 * NUM_DIGITS;
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);
  localparam logic [6:0]       SEG_OFF  = 7'h7F;

  // Active-low g..a segment pattern for one hex nibble.
  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  logic [VAL_W-1:0]      shadow_q, shadow_d;
  logic [VAL_W-1:0]      display_q, display_d;
  logic                  pending_q, pending_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [BLK_W-1:0]      blk_cnt_q, blk_cnt_d;
  logic                  blink_phase_q, blink_phase_d;
  logic                  boundary_q;
  logic                  frame_tick_q;
  logic [6:0]            hex_seg_q, hex_seg_d;
  logic [NUM_DIGITS-1:0] dig_en_q, dig_en_d;
  logic [ALL_W-1:0]      hex_all_q, hex_all_d;

  logic                  scan_term;
  logic                  frame_end;
  logic                  zero_run;
  logic [NUM_DIGITS-1:0] blank_vec;

  // Prescaler, digit index and frame boundary detection.
  always_comb begin
    scan_term = (cnt_q == CNT_LAST);
    frame_end = scan_term && (idx_q == IDX_LAST);
    cnt_d     = scan_term ? '0 : cnt_q + CNT_W'(1);
    idx_d     = idx_q;
    if (scan_term) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Shadow/pending capture; display only changes on a frame boundary.
  always_comb begin
    shadow_d  = shadow_q;
    pending_d = pending_q;
    display_d = display_q;
    if (load) begin
      shadow_d = value_in;
    end
    if (frame_end) begin
      pending_d = 1'b0;
      if (load) begin
        display_d = value_in;
      end else if (pending_q) begin
        display_d = shadow_q;
      end
    end else if (load) begin
      pending_d = 1'b1;
    end
  end

  // Blink phase flips every BLINK_FRAMES frame boundaries.
  always_comb begin
    blk_cnt_d     = blk_cnt_q;
    blink_phase_d = blink_phase_q;
    if (frame_end) begin
      if (blk_cnt_q == BLK_LAST) begin
        blk_cnt_d     = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blk_cnt_d = blk_cnt_q + BLK_W'(1);
      end
    end
  end

  // Per-digit segments; zero_run tracks "this nibble and all above are zero".
  always_comb begin
    zero_run  = 1'b1;
    blank_vec = '0;
    hex_all_d = '1;
    hex_seg_d = SEG_OFF;
    dig_en_d  = '1;
    for (int k = int'(NUM_DIGITS) - 1; k >= 0; k--) begin
      zero_run     = zero_run & (display_q[4*k +: 4] == 4'h0);
      blank_vec[k] = blank_mask[k]
                   | (blink_phase_q & blink_mask[k])
                   | (lz_en & (k > 0) & zero_run);
      hex_all_d[7*k +: 7] = blank_vec[k] ? SEG_OFF : seg7(display_q[4*k +: 4]);
    end
    for (int k = 0; k < int'(NUM_DIGITS); k++) begin
      if (idx_q == IDX_W'(k)) begin
        hex_seg_d   = hex_all_d[7*k +: 7];
        dig_en_d[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESETN) begin
    if (!RESETN) begin
      shadow_q      <= '0;
      display_q     <= '0;
      pending_q     <= 1'b0;
      cnt_q         <= '0;
      idx_q         <= '0;
      blk_cnt_q     <= '0;
      blink_phase_q <= 1'b0;
      boundary_q    <= 1'b0;
      frame_tick_q  <= 1'b0;
      hex_seg_q     <= SEG_OFF;
      dig_en_q      <= '1;
      hex_all_q     <= '1;
    end else begin
      shadow_q      <= shadow_d;
      display_q     <= display_d;
      pending_q     <= pending_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      blk_cnt_q     <= blk_cnt_d;
      blink_phase_q <= blink_phase_d;
      // Two stages so the tick lines up with digit 0 appearing on DIG_EN.
      boundary_q    <= frame_end;
      frame_tick_q  <= boundary_q;
      hex_seg_q     <= hex_seg_d;
      dig_en_q      <= dig_en_d;
      hex_all_q     <= hex_all_d;
    end
  end

  assign HEX_SEG    = hex_seg_q;
  assign DIG_EN     = dig_en_q;
  assign HEX_ALL    = hex_all_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_hex_display_scan.sv
// Scoreboard bench for hex_display_scan (4 digits, SCAN_DIV=2, BLINK_FRAMES=2):
// stimulus queues expected outputs, a single monitor process compares them.
module tb_hex_display_scan;

  logic        CLOCK_50;
  logic        RESETN;
  logic [15:0] value_in;
  logic        load;
  logic        lz_en;
  logic [3:0]  blank_mask;
  logic [3:0]  blink_mask;
  logic [6:0]  HEX_SEG;
  logic [3:0]  DIG_EN;
  logic [27:0] HEX_ALL;
  logic        frame_tick;

  hex_display_scan #(
    .NUM_DIGITS  (4),
    .SCAN_DIV    (2),
    .BLINK_FRAMES(2)
  ) dut (
    .CLOCK_50  (CLOCK_50),
    .RESETN    (RESETN),
    .value_in  (value_in),
    .load      (load),
    .lz_en     (lz_en),
    .blank_mask(blank_mask),
    .blink_mask(blink_mask),
    .HEX_SEG   (HEX_SEG),
    .DIG_EN    (DIG_EN),
    .HEX_ALL   (HEX_ALL),
    .frame_tick(frame_tick)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct packed {
    logic [3:0]  dig_en;
    logic [27:0] hex_all;
  } scan_t;

  scan_t       scan_q[$];
  logic [27:0] frame_q[$];
  int          rst_q[$];
  logic        done;
  int          checks;
  int          failures;
  int          nfr;
  logic [6:0]  seg_tab [16];

  function automatic logic [27:0] pk(input logic [6:0] d3, d2, d1, d0);
    return {d3, d2, d1, d0};
  endfunction

  task automatic chk(input string nm, input logic [27:0] act, input logic [27:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  // Monitor: sample 2 time units after each rising edge.
  initial begin : monitor
    scan_t       se;
    logic [27:0] fe;
    checks   = 0;
    failures = 0;
    forever begin
      @(posedge CLOCK_50);
      #2;
      if (!RESETN && rst_q.size() > 0) begin
        void'(rst_q.pop_front());
        chk("rst_hex_seg", 28'(HEX_SEG), 28'h7F);
        chk("rst_dig_en", 28'(DIG_EN), 28'hF);
        chk("rst_hex_all", HEX_ALL, 28'hFFFFFFF);
        chk("rst_frame_tick", 28'(frame_tick), 28'h0);
      end
      if (RESETN && scan_q.size() > 0) begin
        se = scan_q.pop_front();
        chk("scan_dig_en", 28'(DIG_EN), 28'(se.dig_en));
        chk("scan_hex_all", HEX_ALL, se.hex_all);
      end
      if (frame_tick && frame_q.size() > 0) begin
        fe = frame_q.pop_front();
        chk("frame_hex_all", HEX_ALL, fe);
        chk("frame_dig_en", 28'(DIG_EN), 28'hE);
      end
      if (done) begin
        chk("queues_drained", 28'(scan_q.size() + frame_q.size() + rst_q.size()), 28'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  // Returns on the negedge inside the cycle where frame_tick is high.
  task automatic wait_tick();
    int n = 0;
    do begin
      @(negedge CLOCK_50);
      n++;
    end while (!frame_tick && n < 40);
    if (!frame_tick) begin
      $display("FAIL wait_tick got=no_tick exp=tick_within_40_cycles");
      $fatal(1, "frame_tick timeout");
    end
    nfr++;
  endtask

  task automatic push_release_seq();
    logic [3:0] seq [8];
    seq = '{4'hE, 4'hE, 4'hD, 4'hD, 4'hB, 4'hB, 4'h7, 4'h7};
    for (int i = 0; i < 8; i++) scan_q.push_back({seq[i], 28'h8102040});
  endtask

  task automatic load_now(input logic [15:0] v);
    value_in = v;
    load     = 1'b1;
    step(1);
    load     = 1'b0;
  endtask

  initial begin : stimulus
    logic [6:0] b;
    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    done       = 1'b0;
    nfr        = 0;
    RESETN     = 1'b0;
    value_in   = '0;
    load       = 1'b0;
    lz_en      = 1'b0;
    blank_mask = '0;
    blink_mask = '0;
    rst_q.push_back(0);
    step(3);
    push_release_seq();
    RESETN = 1'b1;
    wait_tick();

    // Mid-scan reset discards a pending load.
    load_now(16'hBEEF);
    step(2);
    @(posedge CLOCK_50);
    #1;
    rst_q.push_back(0);
    RESETN = 1'b0;
    step(2);
    push_release_seq();
    frame_q.push_back(pk(7'h40, 7'h40, 7'h40, 7'h40));
    RESETN = 1'b1;
    nfr = 0;
    wait_tick();

    // Tear-free load with 3 cycles left in the frame.
    step(4);
    load_now(16'h12AF);
    scan_q.push_back({4'h7, 28'h8102040});
    scan_q.push_back({4'h7, 28'h8102040});
    frame_q.push_back(pk(7'h79, 7'h24, 7'h08, 7'h0E));
    wait_tick();

    // Last load wins; load on the boundary cycle applies immediately.
    value_in = 16'h1111;
    load     = 1'b1;
    step(1);
    value_in = 16'h2222;
    step(1);
    load     = 1'b0;
    frame_q.push_back(pk(7'h24, 7'h24, 7'h24, 7'h24));
    wait_tick();
    step(6);
    frame_q.push_back(pk(7'h30, 7'h30, 7'h30, 7'h30));
    load_now(16'h3333);
    wait_tick();
    frame_q.push_back(pk(7'h30, 7'h30, 7'h30, 7'h30));
    wait_tick();

    // Leading-zero suppression.
    lz_en = 1'b1;
    load_now(16'h00A0);
    frame_q.push_back(pk(7'h7F, 7'h7F, 7'h08, 7'h40));
    wait_tick();
    load_now(16'h0000);
    frame_q.push_back(pk(7'h7F, 7'h7F, 7'h7F, 7'h40));
    wait_tick();
    lz_en = 1'b0;

    // Blink on digit 0, phase toggles every 2 frames.
    blink_mask = 4'b0001;
    load_now(16'h8888);
    for (int i = 1; i <= 4; i++) begin
      b = (((nfr + i) / 2) % 2 == 1) ? 7'h7F : 7'h00;
      frame_q.push_back(pk(7'h00, 7'h00, 7'h00, b));
    end
    repeat (4) wait_tick();
    blank_mask = 4'b1000;
    for (int i = 1; i <= 4; i++) begin
      b = (((nfr + i) / 2) % 2 == 1) ? 7'h7F : 7'h00;
      frame_q.push_back(pk(7'h7F, 7'h00, 7'h00, b));
    end
    repeat (4) wait_tick();
    blank_mask = '0;
    blink_mask = '0;

    // Full decode sweep on digit 0.
    for (int v = 0; v < 16; v++) begin
      load_now(16'(v));
      frame_q.push_back(pk(7'h40, 7'h40, 7'h40, seg_tab[v]));
      wait_tick();
    end

    step(3);
    done = 1'b1;
    step(20);
    $display("FAIL monitor_end got=running exp=finished");
    $fatal(1, "monitor did not finish");
  end

endmodule

// File: doc/hex_display_scan.md
Name: hex_display_scan

Overview:
- Parametrised N-digit hexadecimal 7-segment driver; successor to the single-digit combinational nibble decoder.
- Latches a multi-nibble value on a load strobe and applies it tear-free at frame boundaries.
- Drives both a time-multiplexed shared segment bus with digit enables and a static per-digit segment bus.
- Adds leading-zero suppression, per-digit blanking and per-digit blink.

Parameters:
NUM_DIGITS, 4, number of hex digits (legal 1..8)
SCAN_DIV, 50000, clock cycles each digit is enabled in scan mode (legal >= 1)
BLINK_FRAMES, 250, scan frames per blink half-period (legal >= 1)

Ports:
CLOCK_50  in  1  system clock, rising edge
RESETN  in  1  reset, asynchronous assert, active-low
value_in  in  4*NUM_DIGITS  hex value; nibble k maps to digit k, digit 0 is least significant
load  in  1  single-cycle strobe; captures value_in
lz_en  in  1  1 = blank leading zero digits
blank_mask  in  NUM_DIGITS  1 = force digit blank
blink_mask  in  NUM_DIGITS  1 = digit blinks
HEX_SEG  out  7  shared segment bus, active-low, bit0=a … bit6=g
DIG_EN  out  NUM_DIGITS  digit enables, active-low, one-hot-low
HEX_ALL  out  7*NUM_DIGITS  static segments, digit k in bits [7k+6:7k], active-low
frame_tick  out  1  one-cycle pulse at each frame boundary

Behaviour:
- Reset is asynchronous and active-low. Single clock domain, CLOCK_50.
- Reset values: all internal registers are 0, including shadow, display, pending, prescaler, digit index, blink counter and blink_phase.
- Reset output values: HEX_SEG=7'h7F; DIG_EN all 1; HEX_ALL all 1; frame_tick=0.
- Reset asserted mid-operation: outputs return to the reset values immediately; a pending load is discarded.
- Decode, active-low g..a, for 0-F: 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E. Blank is 7F.
- Load:
  - load=1 → shadow <= value_in; pending <= 1.
  - A later load before the frame boundary overwrites shadow; the last value wins.
- Prescaler: counts 0..SCAN_DIV-1. At terminal count it wraps to 0 and digit index advances mod NUM_DIGITS.
- Frame boundary: prescaler terminal with index NUM_DIGITS-1, i.e. index wraps to 0. On that cycle:
  - frame_tick=1.
  - If pending, display <= shadow and pending <= 0.
  - If load is also 1, display <= value_in directly and pending stays 0.
- Blink:
  - Blink counter counts frame boundaries 0..BLINK_FRAMES-1.
  - At terminal it wraps and blink_phase toggles.
  - When blink_phase=1, digits with blink_mask=1 are blank.
- Digit k is blank if any of the following holds:
  - blank_mask[k]=1;
  - blink_phase=1 and blink_mask[k]=1;
  - lz_en=1, k>0, and display nibbles k..NUM_DIGITS-1 are all zero. Digit 0 is never zero-suppressed.
  - blank_mask and blink_mask are sampled live, not shadowed.
- HEX_ALL: registered every cycle from display plus the blank rules; latency 1 cycle.
- Scan outputs, registered, latency 1 cycle from index change:
  - DIG_EN[index]=0, all other bits 1.
  - HEX_SEG = segments of digit index.
- frame_tick is registered and aligned with the first cycle index=0 appears on DIG_EN.
- NUM_DIGITS=1: every prescaler terminal is a frame boundary; DIG_EN stays 0.
- SCAN_DIV=1: index advances every cycle.

Test Plan:
Bench parameters: NUM_DIGITS=4, SCAN_DIV=2, BLINK_FRAMES=2.
1. Reset: drive RESETN=0 mid-scan → HEX_SEG=7F, DIG_EN=4'hF, HEX_ALL=28'hFFFFFFF asynchronously; after release DIG_EN sequences E,D,B,7, each held 2 cycles.
2. Tear-free load: load value_in=16'h12AF with 3 cycles left in the frame → HEX_ALL unchanged until the boundary; then HEX_ALL={79,24,08,0E} for digits 3..0 and frame_tick pulses once.
3. Last-wins and simultaneous: load 16'h1111 then 16'h2222 in the same frame → display shows 2222. Load 16'h3333 on the exact boundary cycle → 3333 is applied at that boundary with no extra frame of delay.
4. Leading zero: value 16'h00A0, lz_en=1 → digits 3,2 = 7F, digit 1 = 08, digit 0 = 40. Value 16'h0000 → only digit 0 shows 40.
5. Blink/blank: blink_mask=4'b0001, value 16'h8888 → digit 0 alternates 00 and 7F every 2 frames. blank_mask=4'b1000 → digit 3 stays 7F throughout.
6. Full decode sweep: load 0..F sequentially into digit 0 → HEX_ALL[6:0] matches the decode table above for every nibble.
